sobel_frame_ctrl: RTL and testbench

//  Frame-level scheduler for the Sobel pipeline; sits between the pixel source and the line-buffer/window/position datapath.

---
 rtl/sobel_frame_ctrl_if.sv | 34 +++
 rtl/sobel_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_ctrl_if.sv
// rtl/sobel_frame_ctrl_if.sv - handshake and status bundle for sobel_frame_ctrl
// Purpose: groups the pixel-source handshake, the downstream advance strobe and
//   the frame status signals of the Sobel frame controller.
// Signals:
//   s_valid, s_sof       source beat valid / start-of-frame marker
//   s_ready              controller accepts the source beat
//   m_ready              downstream can take one window advance
//   count_en, pad_sel    datapath advance strobe / zero-pad select
//   busy, frame_done     controller not idle / last flush beat consumed
//   frame_cnt[15:0]      completed frames
//   err_resync           sticky early-SOF flag
// Modports: slave = controller side, master = source/downstream/observer side.
interface sobel_frame_ctrl_if;
  logic        s_valid;
  logic        s_sof;
  logic        s_ready;
  logic        m_ready;
  logic        count_en;
  logic        pad_sel;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        err_resync;

  modport slave (
    input  s_valid, s_sof, m_ready,
    output s_ready, count_en, pad_sel, busy, frame_done, frame_cnt, err_resync
  );

  modport master (
    output s_valid, s_sof, m_ready,
    input  s_ready, count_en, pad_sel, busy, frame_done, frame_cnt, err_resync
  );
endinterface

// File: rtl/sobel_frame_ctrl.sv
// rtl/sobel_frame_ctrl.sv - frame-level scheduler for the Sobel pipeline
// Purpose: accepts one RAW_FRAME_COLNUM x RAW_FRAME_ROWNUM frame from the pixel
//   source, then injects COLNUM+1 zero-pad beats to flush the window, then
//   holds BLANK_CYCLES idle cycles before accepting the next frame.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-high
//   bus   sobel_frame_ctrl_if.slave (handshake, advance strobe, status)
// Optional feature: define SOBEL_CTRL_RESYNC_EN to let an early SOF inside a
//   frame abort it and restart at pixel (0,0), setting sticky err_resync.
module sobel_frame_ctrl #(
  parameter int RAW_FRAME_COLNUM = 1920,
  parameter int RAW_FRAME_ROWNUM = 1080,
  parameter int BLANK_CYCLES     = 16
) (
  input  logic               clk,
  input  logic               rst,
  sobel_frame_ctrl_if.slave  bus
);

  localparam logic [11:0] COL_LAST   = 12'(RAW_FRAME_COLNUM - 1);
  localparam logic [11:0] ROW_LAST   = 12'(RAW_FRAME_ROWNUM - 1);
  localparam logic [11:0] FLUSH_LAST = 12'(RAW_FRAME_COLNUM);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, BLANK} state_t;

  state_t      state, state_nxt;
  logic [11:0] col, col_nxt;
  logic [11:0] row, row_nxt;
  logic [11:0] flush_cnt, flush_nxt;
  logic [15:0] blank_cnt, blank_nxt;
  logic [15:0] frame_cnt, frame_nxt;
  logic        s_ready, count_en, pad_sel, frame_done;
`ifdef SOBEL_CTRL_RESYNC_EN
  logic        err_set;
  logic        err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      blank_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      flush_cnt <= flush_nxt;
      blank_cnt <= blank_nxt;
      frame_cnt <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    flush_nxt  = flush_cnt;
    blank_nxt  = blank_cnt;
    frame_nxt  = frame_cnt;
    s_ready    = 1'b0;
    count_en   = 1'b0;
    pad_sel    = 1'b0;
    frame_done = 1'b0;
`ifdef SOBEL_CTRL_RESYNC_EN
    err_set    = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Beats without SOF are consumed and dropped so a source that starts
        // mid-frame cannot stall waiting for us.
        s_ready = bus.m_ready;
        if (bus.s_valid && bus.s_sof && bus.m_ready) begin
          count_en  = 1'b1;
          col_nxt   = 12'd1;
          row_nxt   = '0;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        s_ready  = bus.m_ready;
        count_en = bus.s_valid & bus.m_ready;
`ifdef SOBEL_CTRL_RESYNC_EN
        // Early SOF: this beat becomes pixel (0,0) of a fresh frame.
        if (count_en && bus.s_sof && (col != '0 || row != '0)) begin
          col_nxt = 12'd1;
          row_nxt = '0;
          err_set = 1'b1;
        end else
`endif
        if (count_en) begin
          if (col == COL_LAST) begin
            col_nxt = '0;
            if (row == ROW_LAST) begin
              row_nxt   = '0;
              flush_nxt = '0;
              state_nxt = FLUSH;
            end else begin
              row_nxt = row + 12'd1;
            end
          end else begin
            col_nxt = col + 12'd1;
          end
        end
      end
      FLUSH: begin
        // COLNUM+1 zero beats push the last row through the 3x3 window.
        pad_sel  = 1'b1;
        count_en = bus.m_ready;
        if (count_en) begin
          if (flush_cnt == FLUSH_LAST) begin
            frame_done = 1'b1;
            frame_nxt  = frame_cnt + 16'd1;
            blank_nxt  = '0;
            state_nxt  = BLANK;
          end else begin
            flush_nxt = flush_cnt + 12'd1;
          end
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          state_nxt = IDLE;
        end else begin
          blank_nxt = blank_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SOBEL_CTRL_RESYNC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err_resync = err_q;
`else
  assign bus.err_resync = 1'b0;
`endif

  assign bus.s_ready    = s_ready;
  assign bus.count_en   = count_en;
  assign bus.pad_sel    = pad_sel;
  assign bus.frame_done = frame_done;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb/tb_sobel_frame_ctrl.sv - self-checking bench for sobel_frame_ctrl
module tb_sobel_frame_ctrl;
  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int BLANK = 4;
  localparam int NPIX  = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sobel_frame_ctrl_if bus();

  sobel_frame_ctrl #(
    .RAW_FRAME_COLNUM(COLS),
    .RAW_FRAME_ROWNUM(ROWS),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame progress as plain counts of accepted pixels,
  // flush beats taken and blanking cycles still to wait.
  int          m_acc = 0;
  int          m_fl = 0;
  int          m_blank = 0;
  logic [15:0] m_frames = '0;
  bit          m_err = 1'b0;
  bit          cur_v, cur_s, cur_r;
  logic [5:0]  exp_vec;  // {s_ready, count_en, pad_sel, busy, frame_done, err_resync}

  int n_acc, n_fl, n_done;

  wire [5:0] obs_vec = {bus.s_ready, bus.count_en, bus.pad_sel, bus.busy,
                        bus.frame_done, bus.err_resync};

  function automatic void predict(input bit v, input bit s, input bit r);
    exp_vec = '0;
    exp_vec[0] = m_err;
    if (m_blank > 0) begin
      exp_vec[2] = 1'b1;
    end else if (m_acc == NPIX) begin
      exp_vec[4] = r;
      exp_vec[3] = 1'b1;
      exp_vec[2] = 1'b1;
      exp_vec[1] = r && (m_fl == COLS);
    end else if (m_acc > 0) begin
      exp_vec[5] = r;
      exp_vec[4] = v && r;
      exp_vec[2] = 1'b1;
    end else begin
      exp_vec[5] = r;
      exp_vec[4] = v && s && r;
    end
  endfunction

  function automatic void update();
    if (rst) begin
      m_acc = 0; m_fl = 0; m_blank = 0; m_frames = '0; m_err = 1'b0;
    end else if (m_blank > 0) begin
      m_blank--;
    end else if (m_acc == NPIX) begin
      if (cur_r) begin
        m_fl++;
        if (m_fl == COLS + 1) begin
          m_frames++;
          m_acc = 0;
          m_fl = 0;
          m_blank = BLANK;
        end
      end
    end else if (m_acc > 0) begin
`ifdef SOBEL_CTRL_RESYNC_EN
      if (cur_v && cur_s && cur_r) begin
        m_acc = 1;
        m_err = 1'b1;
      end else
`endif
      if (cur_v && cur_r) m_acc++;
    end else if (cur_v && cur_s && cur_r) begin
      m_acc = 1;
    end
  endfunction

  task automatic drive(input bit v, input bit s, input bit r);
    bus.s_valid = v;
    bus.s_sof   = s;
    bus.m_ready = r;
    cur_v = v; cur_s = s; cur_r = r;
    @(negedge clk);
    predict(v, s, r);
    n_acc  += (bus.count_en === 1'b1 && bus.pad_sel === 1'b0) ? 1 : 0;
    n_fl   += (bus.count_en === 1'b1 && bus.pad_sel === 1'b1) ? 1 : 0;
    n_done += (bus.frame_done === 1'b1) ? 1 : 0;
  endtask

  task automatic advance();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    advance();
    drive(0, 0, 0);
    advance();
    drive(0, 0, 0);
    vectors++;
    if (obs_vec !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outs got %b want %b", obs_vec, 6'b0);
    end
    vectors++;
    if (bus.frame_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_frame_cnt got %0d want 0", bus.frame_cnt);
    end
    advance();
    rst = 1'b0;
  endtask

  // Single frame, optional leading junk beats in IDLE.
  task automatic test_nominal(input int junk);
    int f0;
    bit ok;
    bit v;
    f0 = m_frames; ok = 0; n_acc = 0; n_fl = 0; n_done = 0;
    for (int c = 0; c < 300; c++) begin
      v = (m_frames == f0) && (m_acc < NPIX) && (m_blank == 0);
      if (c < junk) drive(1, 0, 1);
      else drive(v, m_acc == 0, 1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL nominal_outs cyc %0d got %b want %b", c, obs_vec, exp_vec);
      end
      vectors++;
      if (bus.frame_cnt !== m_frames) begin
        miscompares++;
        $display("FAIL nominal_frame_cnt got %0d want %0d", bus.frame_cnt, m_frames);
      end
      advance();
      if (m_frames != f0 && m_blank == 0) begin ok = 1; break; end
    end
    drive(0, 0, 1);
    vectors++;
    if (!ok || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_end done %0d busy %b want idle", ok, bus.busy);
    end
    vectors++;
    if (n_acc != NPIX || n_fl != COLS + 1 || n_done != 1) begin
      miscompares++;
      $display("FAIL nominal_totals got acc %0d flush %0d done %0d want %0d %0d 1",
               n_acc, n_fl, n_done, NPIX, COLS + 1);
    end
    vectors++;
    if (bus.frame_cnt !== 16'(f0 + 1)) begin
      miscompares++;
      $display("FAIL nominal_frame_inc got %0d want %0d", bus.frame_cnt, f0 + 1);
    end
    advance();
  endtask

  task automatic test_backpressure();
    int f0, st1, st2;
    bit ok, v, r;
    f0 = m_frames; ok = 0; st1 = 0; st2 = 0; n_acc = 0; n_fl = 0; n_done = 0;
    for (int c = 0; c < 300; c++) begin
      v = (m_frames == f0) && (m_acc < NPIX) && (m_blank == 0);
      r = 1;
      if (m_acc == 10 && st1 < 3) begin r = 0; st1++; end
      if (m_acc == NPIX && m_fl == 4 && st2 < 3) begin r = 0; st2++; end
      drive(v, m_acc == 0, r);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL backpressure_outs cyc %0d got %b want %b", c, obs_vec, exp_vec);
      end
      vectors++;
      if (!r && (bus.s_ready !== 1'b0 || bus.count_en !== 1'b0)) begin
        miscompares++;
        $display("FAIL backpressure_stall got ready %b ce %b want 0 0", bus.s_ready, bus.count_en);
      end
      advance();
      if (m_frames != f0 && m_blank == 0) begin ok = 1; break; end
    end
    vectors++;
    if (!ok || st1 != 3 || st2 != 3 || n_acc != NPIX || n_fl != COLS + 1) begin
      miscompares++;
      $display("FAIL backpressure_totals got done %0d acc %0d flush %0d want 1 %0d %0d",
               ok, n_acc, n_fl, NPIX, COLS + 1);
    end
  endtask

  task automatic test_gaps();
    int f0;
    bit ok, v;
    f0 = m_frames; ok = 0; n_acc = 0; n_fl = 0; n_done = 0;
    for (int c = 0; c < 300; c++) begin
      v = (m_frames == f0) && (m_acc < NPIX) && (m_blank == 0) && (c % 2 == 0);
      drive(v, m_acc == 0, 1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL gaps_outs cyc %0d got %b want %b", c, obs_vec, exp_vec);
      end
      advance();
      if (m_frames != f0 && m_blank == 0) begin ok = 1; break; end
    end
    vectors++;
    if (!ok || n_acc != NPIX || n_done != 1 || bus.frame_cnt !== 16'(f0 + 1)) begin
      miscompares++;
      $display("FAIL gaps_totals got done %0d acc %0d frames %0d want 1 %0d %0d",
               ok, n_acc, bus.frame_cnt, NPIX, f0 + 1);
    end
  endtask

  task automatic test_resync();
    int f0, want_acc;
    bit ok, v, s, inj;
    bit want_err;
`ifdef SOBEL_CTRL_RESYNC_EN
    want_acc = NPIX + 20; want_err = 1'b1;
`else
    want_acc = NPIX; want_err = 1'b0;
`endif
    f0 = m_frames; ok = 0; inj = 0; n_acc = 0; n_fl = 0; n_done = 0;
    for (int c = 0; c < 300; c++) begin
      v = (m_frames == f0) && (m_acc < NPIX) && (m_blank == 0);
      s = (m_acc == 0) || (m_acc == 20 && !inj);
      if (m_acc == 20 && v) inj = 1;
      drive(v, s, 1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL resync_outs cyc %0d got %b want %b", c, obs_vec, exp_vec);
      end
      advance();
      if (m_frames != f0 && m_blank == 0) begin ok = 1; break; end
    end
    vectors++;
    if (!ok || n_acc != want_acc || bus.err_resync !== want_err ||
        bus.frame_cnt !== 16'(f0 + 1)) begin
      miscompares++;
      $display("FAIL resync_totals got done %0d acc %0d err %b frames %0d want 1 %0d %b %0d",
               ok, n_acc, bus.err_resync, bus.frame_cnt, want_acc, want_err, f0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    bit ok, v, r, s;
    f0 = m_frames; ok = 0; n_acc = 0; n_fl = 0; n_done = 0;
    for (int c = 0; c < 1500; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      s = (m_acc == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      drive(v, s, r);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL b2b_outs cyc %0d got %b want %b", c, obs_vec, exp_vec);
      end
      vectors++;
      if (bus.frame_cnt !== m_frames) begin
        miscompares++;
        $display("FAIL b2b_frame_cnt got %0d want %0d", bus.frame_cnt, m_frames);
      end
      advance();
      if (m_frames == 16'(f0 + 2) && m_blank == 0) begin ok = 1; break; end
    end
    vectors++;
    if (!ok || n_acc != 2 * NPIX || n_fl != 2 * (COLS + 1) || n_done != 2) begin
      miscompares++;
      $display("FAIL b2b_totals got done %0d acc %0d flush %0d fd %0d want 1 %0d %0d 2",
               ok, n_acc, n_fl, n_done, 2 * NPIX, 2 * (COLS + 1));
    end
  endtask

  task automatic test_reset_mid_flush();
    int f0;
    bit found, v;
    f0 = m_frames; found = 0;
    for (int c = 0; c < 300; c++) begin
      if (m_acc == NPIX && m_fl == 3) begin found = 1; break; end
      v = (m_frames == f0) && (m_acc < NPIX) && (m_blank == 0);
      drive(v, m_acc == 0, 1);
      vectors++;
      if (obs_vec !== exp_vec) begin
        miscompares++;
        $display("FAIL midrst_outs cyc %0d got %b want %b", c, obs_vec, exp_vec);
      end
      advance();
    end
    rst = 1'b1;
    drive(0, 0, 1);
    vectors++;
    if (!found || obs_vec !== exp_vec) begin
      miscompares++;
      $display("FAIL midrst_flush reached %0d got %b want %b", found, obs_vec, exp_vec);
    end
    advance();
    rst = 1'b0;
    drive(0, 0, 0);
    vectors++;
    if (obs_vec !== 6'b0) begin
      miscompares++;
      $display("FAIL midrst_after_outs got %b want %b", obs_vec, 6'b0);
    end
    vectors++;
    if (bus.frame_cnt !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_frame_cnt got %0d want 0", bus.frame_cnt);
    end
    advance();
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_nominal(0);
    test_nominal(5);
    test_backpressure();
    test_gaps();
    test_resync();
    test_back_to_back();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
